// File: rtl/ps2_key_sequencer.sv
// PS/2 receiver: synchroniser, frame FSM with timeout, E0/F0 prefix decoder,
// Shift+Alt layout toggle and a show-ahead event FIFO. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_key_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [7:0] evt_code_o,
  output logic       evt_break_o,
  output logic       evt_ext_o,
  output logic       lang_o,
  output logic       frame_err_o,
  output logic       ovf_o
);
  // state  | meaning
  // IDLE   | waiting for a start bit
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the parity bit
  // STOP   | checking stop bit (and parity) before releasing the byte
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]   clk_sync_q, data_sync_q;
  logic         clk_prev_q;
  logic         fe, rx_bit;
  frame_state_e state_q;
  logic [2:0]   bitcnt_q;
  logic [7:0]   shift_q;
  logic [TW-1:0] tmo_q;
  logic         byte_rdy_q, frame_err_q;
  logic         par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic         par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fe     = clk_prev_q & ~clk_sync_q[1];
  assign rx_bit = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fe || state_q == IDLE) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 1'b1;
      if (fe) begin
        case (state_q)
          IDLE: begin
            if (!rx_bit) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q  <= {rx_bit, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= rx_bit;
`endif
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (rx_bit && par_ok) byte_rdy_q  <= 1'b1;
            else                  frame_err_q <= 1'b1;
          end
        endcase
      end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // Partial byte is simply abandoned; byte_rdy never fires for it.
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  logic          ext_pend_q, brk_pend_q, shift_held_q, alt_held_q, lang_q, ovf_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          is_ext, is_brk, is_drop, push, pop, full, wr_en, make;
  logic [9:0]    head;

  always_comb begin
    is_ext  = (shift_q == 8'hE0);
    is_brk  = (shift_q == 8'hF0);
    is_drop = shift_q inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    push    = byte_rdy_q && !is_ext && !is_brk && !is_drop;
    make    = !brk_pend_q;
    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = evt_valid_o && evt_ready_i;
    wr_en   = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      shift_held_q <= 1'b0;
      alt_held_q   <= 1'b0;
      lang_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (byte_rdy_q) begin
        if (is_ext)      ext_pend_q <= 1'b1;
        else if (is_brk) brk_pend_q <= 1'b1;
        else begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
      // Held tracking runs even when the FIFO drops the event.
      if (push && !ext_pend_q) begin
        if (shift_q == 8'h12 || shift_q == 8'h59) shift_held_q <= make;
        if (shift_q == 8'h11) begin
          alt_held_q <= make;
          if (make && !alt_held_q && shift_held_q) lang_q <= ~lang_q;
        end
      end
      if (push && full && !pop) ovf_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ext_pend_q, brk_pend_q, shift_q};
  end

  assign head        = mem_q[rd_ptr_q];
  assign evt_valid_o = (count_q != '0);
  assign evt_code_o  = evt_valid_o ? head[7:0] : 8'h00;
  assign evt_break_o = evt_valid_o & head[8];
  assign evt_ext_o   = evt_valid_o & head[9];
  assign lang_o      = lang_q;
  assign frame_err_o = frame_err_q;
  assign ovf_o       = ovf_q;
endmodule
